status_flag_unit: RTL

STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

---
 rtl/status_flag_unit_pkg.sv | 28 ++
 rtl/status_flag_unit_flag_gen.sv | 34 +++
 rtl/status_flag_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/status_flag_unit_pkg.sv
// Shared processor definitions: ALU command encodings, condition codes and
// the bit positions of the NZCV flags inside the status word.
package status_flag_unit_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_MVN = 4'b1001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000
  } alu_cmd_e;

  // "Always" condition: such an instruction never reads the flags.
  localparam logic [3:0] COND_AL = 4'b1110;

  // Status word layout {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] INFLIGHT_MAX = 2'd3;

endpackage

// File: rtl/status_flag_unit_flag_gen.sv
// Next-flag generator: turns the EXE stage ALU outcome plus the current
// status into the NZCV value that a committing instruction writes.
module flag_gen
  import status_flag_unit_pkg::*;
(
  input  logic [3:0]  i_cmd,
  input  logic [31:0] i_res,
  input  logic        i_op1_msb,
  input  logic        i_op2_msb,
  input  logic        i_cout,
  input  logic [3:0]  i_old,
  output logic [3:0]  o_next
);

  // N/Z always follow the result; C/V only move for arithmetic commands.
  always_comb begin
    o_next         = i_old;
    o_next[FLAG_N] = i_res[31];
    o_next[FLAG_Z] = (i_res == 32'd0);
    case (i_cmd)
      CMD_ADD, CMD_ADC: begin
        o_next[FLAG_C] = i_cout;
        o_next[FLAG_V] = (i_op1_msb == i_op2_msb) & (i_res[31] != i_op1_msb);
      end
      CMD_SUB, CMD_SBC: begin
        // Carry arrives as not-borrow, so it is stored unchanged.
        o_next[FLAG_C] = i_cout;
        o_next[FLAG_V] = (i_op1_msb != i_op2_msb) & (i_res[31] != i_op1_msb);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/status_flag_unit.sv
// Status flag register with in-flight tracking of flag-setting instructions
// so a conditional instruction in ID stalls until the flags it reads land.
module status_flag_unit
  import status_flag_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        id_valid,
  input  logic        id_s,
  input  logic [3:0]  id_cond,
  input  logic        exe_valid,
  input  logic        exe_s,
  input  logic [3:0]  exe_cmd,
  input  logic [31:0] alu_res,
  input  logic        op1_msb,
  input  logic        op2_msb,
  input  logic        alu_cout,
  output logic [3:0]  status,
  output logic        flag_hazard,
  output logic [1:0]  inflight
);

  logic [3:0] r_status;
  logic [1:0] r_inflight;
  logic [3:0] w_next;
  logic       w_commit;
  logic       w_issue;
  logic       w_hazard;

  flag_gen u_flag_gen (
    .i_cmd     (exe_cmd),
    .i_res     (alu_res),
    .i_op1_msb (op1_msb),
    .i_op2_msb (op2_msb),
    .i_cout    (alu_cout),
    .i_old     (r_status),
    .o_next    (w_next)
  );

  // A conditional ID instruction must wait while any flag writer is in flight.
  always_comb begin
    w_hazard = id_valid & (id_cond != COND_AL) & (r_inflight != 2'd0);
    w_commit = exe_valid & exe_s & ~freeze;
    w_issue  = id_valid & id_s & ~freeze & ~flush & ~w_hazard;
  end

  // Flag register: written only by a committing EXE instruction.
  always_ff @(posedge clk) begin
    if (rst)
      r_status <= 4'b0000;
    else if (w_commit)
      r_status <= w_next;
  end

  // In-flight counter; a flush discards ID/EX writers but not the one in EXE.
  always_ff @(posedge clk) begin
    if (rst)
      r_inflight <= 2'd0;
    else if (!freeze) begin
      if (flush)
        r_inflight <= 2'd0;
      else if (w_issue && !w_commit && r_inflight != INFLIGHT_MAX)
        r_inflight <= r_inflight + 2'd1;
      else if (w_commit && !w_issue && r_inflight != 2'd0)
        r_inflight <= r_inflight - 2'd1;
    end
  end

  // Saturation and floor are reachable only through a pipeline bug.
  always_ff @(posedge clk) begin
    if (!rst && !freeze && !flush) begin
      a_inflight_ovf: assert (!(w_issue && !w_commit && r_inflight == INFLIGHT_MAX));
      a_inflight_unf: assert (!(w_commit && !w_issue && r_inflight == 2'd0));
    end
  end

  assign status      = r_status;
  assign inflight    = r_inflight;
  assign flag_hazard = w_hazard;

endmodule
